instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Parametrised instruction memory with a built-in byte-stream program loader. It replaces the fixed 8K-word, externally muxed instruction RAM. The host byte stream (UART RX side) writes a length-prefixed program into an inferred single-port BRAM. The core fetch stage reads it with fixed 1-cycle latency, and the block arbitrates internally between loading and fetching.

Parameters:
ADDR_W, 13, word-address width; memory depth = 2**ADDR_W words
DATA_W, 32, instruction word width; must be a multiple of 8
BYTES, DATA_W/8, bytes per word (derived, not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
load_start  in  1  1-cycle pulse: begin a new program load
rx_valid  in  1  loader byte valid
rx_data  in  8  loader byte
rx_ready  out  1  loader byte accepted when rx_valid && rx_ready
load_busy  out  1  high in LEN or DATA state
load_done  out  1  high in DONE state
load_err  out  1  high in ERR state
word_count  out  ADDR_W+1  words written in the current/last load
proc_re  in  1  fetch request
proc_addr  in  32  fetch byte address
proc_dout  out  DATA_W  fetched word
proc_rvalid  out  1  proc_dout valid, 1 cycle after accepted proc_re
proc_fault  out  1  qualifies proc_rvalid: bad address, proc_dout=0

Behaviour:
- Reset (async, rstn=0): state=IDLE; rx_ready, load_busy, load_done, load_err, proc_rvalid, proc_fault = 0; word_count=0; proc_dout=0; byte index=0. Memory contents are not cleared.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE/DONE/ERR + load_start -> LEN. On entry, clear byte index, word_count and length register.
- load_start in LEN/DATA: ignored.
- rx_ready=1 only in LEN and DATA. Bytes seen in other states are not accepted.
- LEN: accept BYTES bytes, little-endian, into length N. This field is 32 bits for DATA_W=32.
- After the last LEN byte:
  - N==0 -> DONE.
  - N>2**ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA: bytes assemble little-endian (first byte = bits 7:0).
  - On the accepting edge of byte BYTES-1, write {rx_data, shreg} to mem[word_count] in that same cycle, increment word_count and reset the byte index.
  - When the incremented word_count == N -> DONE on the same edge.
- Fetch is accepted only when proc_re=1 and state is not LEN/DATA.
  - Requests during load are dropped: proc_rvalid stays 0 the next cycle. The core must hold fetch until load_done.
- Accepted fetch at edge t: proc_rvalid=1 during cycle t+1, with proc_dout = mem[proc_addr[ADDR_W+1:2]].
- Fault: proc_addr[1:0]!=0 or proc_addr[31:ADDR_W+2]!=0. Then proc_rvalid=1, proc_fault=1 and proc_dout=0 at t+1, and no memory access.
- No accepted fetch: proc_rvalid=0, proc_fault=0, proc_dout holds its last value.
- Back-to-back fetches: one result per cycle, fully pipelined.
- Single BRAM port: the write port is active only in DATA and the read port only outside LEN/DATA, so no collision is possible.
- rstn asserted mid-load: immediate return to IDLE. Partial words are discarded and words already written remain in memory. word_count reads 0.
- DATA_W not a multiple of 8: elaboration error.

Test Plan:
- Reset release, no activity -> all outputs 0, state IDLE, rx_ready=0 for 10 cycles.
- load_start, bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 (random rx_valid gaps) -> mem[0]=0x00000013, mem[1]=0x00100093, word_count=2, load_done=1 one cycle after the last byte accepted.
- After that load, proc_re with addr 0x0,0x4 back-to-back -> proc_rvalid on the next two cycles with dout 0x00000013, 0x00100093, proc_fault=0.
- Fetch addr 0x6 and 0x8000 (ADDR_W=13) -> proc_rvalid=1, proc_fault=1, proc_dout=0 for each.
- Length 0x00002001 with ADDR_W=13 -> load_err=1, rx_ready=0. Then load_start with length 0 -> load_done=1, word_count=0.
- rstn pulse after 6 of 12 DATA bytes -> state IDLE, word_count=0, mem[0] retains the written word. proc_re during LEN/DATA -> proc_rvalid=0.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream loader channel and instruction fetch bus of instr_mem_loader.
// The master side is the host/core, the slave side is the memory block.
interface instr_mem_loader_if #(
  parameter int DATA_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              proc_re;
  logic [31:0]       proc_addr;
  logic [DATA_W-1:0] proc_dout;
  logic              proc_rvalid;
  logic              proc_fault;

  modport master (
    output rx_valid, rx_data, proc_re, proc_addr,
    input  rx_ready, proc_dout, proc_rvalid, proc_fault
  );

  modport slave (
    input  rx_valid, rx_data, proc_re, proc_addr,
    output rx_ready, proc_dout, proc_rvalid, proc_fault
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Single-port instruction memory with a length-prefixed byte-stream loader.
// Loading and fetching share one BRAM port; fetch is locked out while loading.
//
// state  | meaning
// -------+--------------------------------------------------------
// S_IDLE | no load since reset, fetch allowed
// S_LEN  | collecting the little-endian word count N
// S_DATA | collecting program bytes, one memory write per word
// S_DONE | last load completed (word_count = N), fetch allowed
// S_ERR  | last load requested more words than the memory holds
module instr_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count,
  instr_mem_loader_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LW    = ((DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1) + 1;
  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W % 8 != 0) begin : g_width_check
    $error("instr_mem_loader: DATA_W must be a multiple of 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wc_inc;
  logic [LW-1:0]     len_new_x, len_q_x, wc_inc_x, depth_x;
  logic              loading, accept, last_byte, start_ok, mem_we;
  logic              fetch_acc, fetch_bad, mem_re, ok_q;

  assign loading     = (state_q == S_LEN) || (state_q == S_DATA);
  assign bus.rx_ready = loading;
  assign accept      = loading && bus.rx_valid;
  assign last_byte   = (byte_idx == IDX_W'(BYTES - 1));
  assign start_ok    = load_start && !loading;
  assign wc_inc      = word_count + 1'b1;

  // Widened copies so the length compares never truncate for any ADDR_W/DATA_W mix
  assign len_new_x = LW'(asm_word);
  assign len_q_x   = LW'(len_q);
  assign wc_inc_x  = LW'(wc_inc);
  assign depth_x   = LW'(DEPTH);

  assign load_busy = loading;
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);

  // The byte on the bus completes the word, so length and data share this assembly
  always_comb begin
    asm_word = shreg;
    asm_word[DATA_W-1 -: 8] = bus.rx_data;
  end

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept && last_byte) begin
          if (len_new_x == '0)          state_d = S_DONE;
          else if (len_new_x > depth_x) state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && last_byte) begin
          mem_we = 1'b1;
          if (wc_inc_x == len_q_x) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      byte_idx   <= '0;
      shreg      <= '0;
      len_q      <= '0;
      word_count <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        byte_idx   <= '0;
        word_count <= '0;
        len_q      <= '0;
      end else if (accept) begin
        if (last_byte) begin
          byte_idx <= '0;
          if (state_q == S_LEN) len_q <= asm_word;
          else                  word_count <= wc_inc;
        end else begin
          shreg[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  assign fetch_acc = bus.proc_re && !loading;
  assign fetch_bad = (bus.proc_addr[1:0] != 2'b00) ||
                     ((bus.proc_addr >> (ADDR_W + 2)) != 32'd0);
  assign mem_re    = fetch_acc && !fetch_bad;

  // Write only happens in S_DATA and read only outside loading, so one port suffices
  always_ff @(posedge clk) begin
    if (mem_we)      mem[word_count[ADDR_W-1:0]] <= asm_word;
    else if (mem_re) rd_q <= mem[bus.proc_addr[ADDR_W+1:2]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.proc_rvalid <= 1'b0;
      bus.proc_fault  <= 1'b0;
      ok_q            <= 1'b0;
    end else begin
      bus.proc_rvalid <= fetch_acc;
      bus.proc_fault  <= fetch_acc && fetch_bad;
      if (fetch_acc) ok_q <= !fetch_bad;
    end
  end

  // ok_q gates the raw BRAM register so faults and reset show zero and idle cycles hold
  assign bus.proc_dout = ok_q ? rd_q : '0;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised bench for instr_mem_loader: a word-level memory model predicts fetch
// results into a queue that a negedge monitor pops whenever proc_rvalid is seen.
module tb_instr_mem_loader;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic load_start = 1'b0;
  logic load_busy, load_done, load_err;
  logic [ADDR_W:0] word_count;

  instr_mem_loader_if #(.DATA_W(DATA_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] data;
  } exp_t;

  int n_total = 0;
  int n_pass  = 0;
  exp_t sbq[$];
  logic [31:0] ref_mem [int];
  logic [31:0] prog[$];
  logic [31:0] last_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: word-addressed memory, any misaligned or out-of-range byte address faults
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    if ((a % 4) != 0 || a >= 32'(4 * DEPTH)) begin
      e.fault = 1'b1;
      e.data  = '0;
    end else begin
      e.fault = 1'b0;
      e.data  = ref_mem.exists(int'(a / 4)) ? ref_mem[int'(a / 4)] : 'x;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      last_dout = '0;
    end else if (bus.proc_rvalid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", 64'(bus.proc_rvalid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("fetch_fault", 64'(bus.proc_fault), 64'(e.fault));
        chk("fetch_dout", 64'(bus.proc_dout), 64'(e.data));
        last_dout = e.data;
      end
    end else begin
      chk("idle_fault", 64'(bus.proc_fault), 64'd0);
      chk("idle_dout_hold", 64'(bus.proc_dout), 64'(last_dout));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = bus.rx_ready;
      cyc();
    end
    if (!acc) chk("rx_accept_timeout", 64'(bus.rx_ready), 64'd1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic drop_fetch(input string name);
    bus.proc_re   = 1'b1;
    bus.proc_addr = '0;
    cyc();
    bus.proc_re = 1'b0;
    chk(name, 64'(bus.proc_rvalid), 64'd0);
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    bus.proc_re   = 1'b1;
    bus.proc_addr = a;
    sbq.push_back(model(a));
    cyc();
  endtask

  // Runs one load of length n from prog; reset_after >= 0 pulses rstn after that many data bytes
  task automatic run_load(input logic [31:0] n, input int reset_after, input bit poke_start);
    int cnt;
    logic [31:0] w;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    chk("start_busy", 64'(load_busy), 64'd1);
    chk("start_wc_clear", 64'(word_count), 64'd0);
    drop_fetch("drop_in_len");
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8]);
    if (n == 0) begin
      chk("len0_done", 64'(load_done), 64'd1);
      chk("len0_wc", 64'(word_count), 64'd0);
      chk("len0_ready", 64'(bus.rx_ready), 64'd0);
      return;
    end
    if (n > 32'(DEPTH)) begin
      chk("toolong_err", 64'(load_err), 64'd1);
      chk("toolong_ready", 64'(bus.rx_ready), 64'd0);
      chk("toolong_busy", 64'(load_busy), 64'd0);
      return;
    end
    chk("data_busy", 64'(load_busy), 64'd1);
    chk("data_no_err", 64'(load_err), 64'd0);
    cnt = 0;
    for (int i = 0; i < int'(n); i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        if (cnt == reset_after) begin
          rstn = 1'b0;
          #1;
          chk("rst_busy", 64'(load_busy), 64'd0);
          chk("rst_wc", 64'(word_count), 64'd0);
          chk("rst_ready", 64'(bus.rx_ready), 64'd0);
          chk("rst_status", 64'({load_done, load_err}), 64'd0);
          cyc();
          rstn = 1'b1;
          cyc();
          return;
        end
        if (poke_start && i == 1 && b == 0) begin
          load_start = 1'b1;
          cyc();
          load_start = 1'b0;
          chk("start_ignored_wc", 64'(word_count), 64'd1);
          chk("start_ignored_busy", 64'(load_busy), 64'd1);
        end
        send_byte(w[8*b +: 8]);
        cnt++;
      end
      ref_mem[i] = w;
      if (i < int'(n) - 1) chk("word_progress", 64'(word_count), 64'(i + 1));
      if (i == 0 && n > 1) drop_fetch("drop_in_data");
    end
    chk("load_done", 64'(load_done), 64'd1);
    chk("load_wc", 64'(word_count), 64'(n));
    chk("done_ready", 64'(bus.rx_ready), 64'd0);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.proc_re = 1'b0;
    bus.proc_addr = '0;
    #1 rstn = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("reset_outputs", 64'({bus.rx_ready, load_busy, load_done, load_err, word_count,
                                 bus.proc_rvalid, bus.proc_fault, bus.proc_dout}), 64'd0);
    end

    prog = '{32'h0000_0013, 32'h0010_0093};
    run_load(32'd2, -1, 1'b0);
    issue_fetch(32'h0);
    issue_fetch(32'h4);
    issue_fetch(32'h6);
    issue_fetch(32'h8000);
    bus.proc_re = 1'b0;
    repeat (2) cyc();

    run_load(32'h0000_2001, -1, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (3) begin
      cyc();
      chk("err_no_accept", 64'(bus.rx_ready), 64'd0);
    end
    bus.rx_valid = 1'b0;
    run_load(32'd0, -1, 1'b0);

    prog.delete();
    for (int i = 0; i < 24; i++) prog.push_back($urandom);
    run_load(32'd24, -1, 1'b1);
    for (int j = 0; j < 60; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.proc_re = 1'b0;
        cyc();
      end
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 23)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 23)) * 4 + 32'($urandom_range(1, 3));
      else             a = $urandom | 32'h0000_8000;
      issue_fetch(a);
    end
    bus.proc_re = 1'b0;
    repeat (2) cyc();

    run_load(32'(DEPTH), 0, 1'b0);

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back($urandom);
    run_load(32'd3, 6, 1'b0);
    issue_fetch(32'h0);
    issue_fetch(32'h4);
    issue_fetch(32'h8);
    bus.proc_re = 1'b0;
    repeat (3) cyc();

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
